led_pattern_pio: RTL and testbench
==================================

LED_PATTERN_PIO -- requirements
Module: led_pattern_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output port width (1..32).
REQ-002 SHALL have parameter PRE_W, default 24, prescaler width (1..32).
REQ-003 SHALL have parameter RST_PATTERN, default 1, DATA value after reset (WIDTH bits).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  3  Avalon-MM register word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, combinational from address, zero wait states.
REQ-011 SHALL have port out_port  output  WIDTH  LED drive.
REQ-012 SHALL have port irq  output  1  level interrupt, high while STATUS.wrap and CTRL.irq_en.

Function
REQ-013 SHALL decode a write as chipselect=1 and write_n=0 on a rising edge; unlisted addresses ignore writes and read 0.
REQ-014 SHALL implement addr 0 DATA (RW): pattern register, writedata[WIDTH-1:0]; readdata upper bits 0.
REQ-015 SHALL implement addr 1 CTRL (RW): bit0 run, bit1 dir (0=left/toward MSB, 1=right), bit2 mode (0=rotate, 1=bounce), bit3 invert, bit4 irq_en; other bits read 0.
REQ-016 SHALL implement addr 2 PRESCALE (RW): reload value, writedata[PRE_W-1:0].
REQ-017 SHALL implement addr 3 STATUS: bit0 wrap (sticky, write-1-to-clear), bit1 running (=CTRL.run, read-only).
REQ-018 SHALL implement addr 4 SET (W): DATA <= DATA | wd; addr 5 CLR (W): DATA <= DATA & ~wd; addr 6 TGL (W): DATA <= DATA ^ wd; all read 0.
REQ-019 SHALL drive out_port = DATA XOR {WIDTH{CTRL.invert}}, registered-path only (no combinational path from writedata).
REQ-020 SHALL, while run=1, count down a PRE_W-bit counter each cycle and assert a one-cycle tick when count==0, reloading PRESCALE; tick period = PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
REQ-021 SHALL hold the counter at PRESCALE while run=0, and load PRESCALE the cycle run goes 0->1 (first tick PRESCALE+1 cycles after the write).
REQ-022 SHALL, on tick in rotate mode, rotate DATA one place in dir; wrap set when the bit rotated out of the end (DATA[WIDTH-1] for left, DATA[0] for right) was 1.
REQ-023 SHALL, on tick in bounce mode, shift in dir unless the end bit in dir is 1, in which case toggle CTRL.dir, shift the opposite way this tick, and set wrap; zeros shifted in.
REQ-024 SHALL, for WIDTH=1 in bounce mode, leave DATA unchanged, toggle dir and set wrap each tick when DATA=1.
REQ-025 SHALL leave DATA unchanged and wrap unset on tick when DATA=0.
REQ-026 SHALL give CPU writes to DATA/SET/CLR/TGL priority over a same-cycle tick; that tick's shift is discarded and the counter reloads normally.
REQ-027 SHALL give a CPU CTRL write priority over a same-cycle hardware dir toggle.
REQ-028 SHALL let a hardware wrap set win over a same-cycle STATUS write-1-to-clear.
REQ-029 SHALL update DATA, CTRL and STATUS one cycle after the write edge; readdata reflects the new value that cycle.

Reset
REQ-030 SHALL on reset set DATA=RST_PATTERN, CTRL=0, PRESCALE=all ones, counter=all ones, wrap=0; hence out_port=RST_PATTERN, irq=0, readdata per address.
REQ-031 SHALL let reset mid-operation take effect at the next edge, overriding any same-cycle write or tick.

Structure
REQ-032 SHALL place register address constants (ADDR_DATA..ADDR_TGL) and CTRL/STATUS bit indices in shared package led_pio_pkg.
REQ-033 SHALL implement the prescaler as sub-module led_tick_gen (inputs clk, reset, en, reload; output tick).

Verification
REQ-034 SHALL cover: reset -> out_port=0x01, readdata @addr1=0, irq=0.
REQ-035 SHALL cover: PRESCALE=3, CTRL=0x01 -> DATA 0x01,0x02,0x04 at 4-cycle intervals; after 0x80 next tick 0x01 with wrap=1.
REQ-036 SHALL cover: DATA=0x01, CTRL=0x07 (bounce,right), PRESCALE=0 -> first tick dir flips to 0, DATA=0x02, wrap=1; then up to 0x80, then 0x40 with dir=1.
REQ-037 SHALL cover: DATA=0x0F, SET 0xF0 -> 0xFF; CLR 0x81 -> 0x7E; TGL 0xFF -> 0x81; CTRL.invert=1 -> out_port=0x7E.
REQ-038 SHALL cover: CTRL=0x11, PRESCALE=0, DATA=0x80 -> irq=1 after tick; STATUS write 0x1 -> irq=0 next cycle; clear coincident with wrap -> wrap stays 1.
REQ-039 SHALL cover: DATA write 0x55 coincident with tick -> DATA=0x55, no shift that cycle; reset asserted mid-run -> DATA=0x01, run=0.

Source files
------------

// File: rtl/led_pio_pkg.sv
// Shared register map and CTRL/STATUS field layout for the LED pattern PIO.
package led_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_CTRL     = 3'd1,
        ADDR_PRESCALE = 3'd2,
        ADDR_STATUS   = 3'd3,
        ADDR_SET      = 3'd4,
        ADDR_CLR      = 3'd5,
        ADDR_TGL      = 3'd6
    } reg_addr_e;

    localparam int unsigned CTRL_RUN_BIT    = 0;
    localparam int unsigned CTRL_DIR_BIT    = 1;
    localparam int unsigned CTRL_MODE_BIT   = 2;
    localparam int unsigned CTRL_INVERT_BIT = 3;
    localparam int unsigned CTRL_IRQ_EN_BIT = 4;
    localparam int unsigned CTRL_W          = 5;

    localparam int unsigned STATUS_WRAP_BIT    = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

    // Member order puts run at bit 0, matching the CTRL_*_BIT indices.
    typedef struct packed {
        logic irq_en;
        logic invert;
        logic mode;
        logic dir;
        logic run;
    } ctrl_t;

    // Addresses whose write replaces or modifies the pattern register.
    function automatic logic is_data_addr(input logic [2:0] a);
        return (a == ADDR_DATA) || (a == ADDR_SET) ||
               (a == ADDR_CLR)  || (a == ADDR_TGL);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: down-counter that emits a one-cycle tick every reload+1 cycles while enabled.
module led_tick_gen
    import led_pio_pkg::*;
#(
    parameter int unsigned PRE_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PRE_W-1:0] reload,
    output logic             tick
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Holding at reload while disabled gives a full first period on enable.
    always_comb begin
        tick  = en && (cnt_q == '0);
        cnt_d = cnt_q - PRE_W'(1);
        if (!en || tick) begin
            cnt_d = reload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_pio.sv
// Avalon-MM LED pattern peripheral: rotating/bouncing pattern with sticky wrap status and irq.
module led_pattern_pio
    import led_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       PRE_W       = 24,
    parameter logic [WIDTH-1:0]  RST_PATTERN = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [PRE_W-1:0] pre_q,  pre_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic             wr;
    logic             wr_data;
    logic             wr_ctrl;
    logic             wr_pre;
    logic             wr_status;
    logic             tick_apply;

    logic [WIDTH-1:0] shift_data;
    logic             dir_flip;
    logic             wrap_hit;
    logic             end_bit;

    logic             unused_wd;
    assign unused_wd = ^writedata;

    led_tick_gen #(
        .PRE_W (PRE_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl_q.run),
        .reload (pre_q),
        .tick   (tick)
    );

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] d);
        return (d << 1) | (d >> (WIDTH - 1));
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] d);
        return (d >> 1) | (d << (WIDTH - 1));
    endfunction

    always_comb begin
        wr        = chipselect && !write_n;
        wr_data   = wr && is_data_addr(address);
        wr_ctrl   = wr && (address == ADDR_CTRL);
        wr_pre    = wr && (address == ADDR_PRESCALE);
        wr_status = wr && (address == ADDR_STATUS);
    end

    // Pattern movement for a tick, evaluated from current state only.
    always_comb begin
        shift_data = data_q;
        dir_flip   = 1'b0;
        wrap_hit   = 1'b0;
        end_bit    = ctrl_q.dir ? data_q[0] : data_q[WIDTH-1];
        if (!ctrl_q.mode) begin
            wrap_hit   = end_bit;
            shift_data = ctrl_q.dir ? rot_right(data_q) : rot_left(data_q);
        end else if (end_bit) begin
            dir_flip = 1'b1;
            wrap_hit = 1'b1;
            if (WIDTH > 1) begin
                shift_data = ctrl_q.dir ? (data_q << 1) : (data_q >> 1);
            end
        end else begin
            shift_data = ctrl_q.dir ? (data_q >> 1) : (data_q << 1);
        end
    end

    // A CPU pattern write swallows a coincident tick entirely (shift, flip and wrap).
    assign tick_apply = tick && !wr_data;

    always_comb begin
        data_d = data_q;
        if (wr_data) begin
            case (address)
                ADDR_DATA: data_d = writedata[WIDTH-1:0];
                ADDR_SET:  data_d = data_q |  writedata[WIDTH-1:0];
                ADDR_CLR:  data_d = data_q & ~writedata[WIDTH-1:0];
                ADDR_TGL:  data_d = data_q ^  writedata[WIDTH-1:0];
                default:   data_d = data_q;
            endcase
        end else if (tick_apply) begin
            data_d = shift_data;
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(writedata[CTRL_W-1:0]);
        end else if (tick_apply && dir_flip) begin
            ctrl_d.dir = ~ctrl_q.dir;
        end
    end

    always_comb begin
        pre_d = pre_q;
        if (wr_pre) begin
            pre_d = writedata[PRE_W-1:0];
        end
    end

    // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
    always_comb begin
        wrap_d = wrap_q;
        if (wr_status && writedata[STATUS_WRAP_BIT]) begin
            wrap_d = 1'b0;
        end
        if (tick_apply && wrap_hit) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RST_PATTERN;
            ctrl_q <= '0;
            pre_q  <= '1;
            wrap_q <= 1'b0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]  = data_q;
            ADDR_CTRL:     readdata[CTRL_W-1:0] = ctrl_q;
            ADDR_PRESCALE: readdata[PRE_W-1:0]  = pre_q;
            ADDR_STATUS: begin
                readdata[STATUS_WRAP_BIT]    = wrap_q;
                readdata[STATUS_RUNNING_BIT] = ctrl_q.run;
            end
            default:       readdata = '0;
        endcase
    end

    assign out_port = data_q ^ {WIDTH{ctrl_q.invert}};
    assign irq      = wrap_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_led_pattern_pio.sv
// Scoreboard bench for led_pattern_pio: expectations queued with stimulus, drained at negedge.
module tb_led_pattern_pio;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int unsigned n_checks;
    int unsigned n_pass;

    typedef enum int unsigned { K_RD, K_OUT, K_IRQ } kind_e;

    typedef struct {
        string       tag;
        kind_e       kind;
        logic [2:0]  addr;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];

    led_pattern_pio #(
        .WIDTH       (8),
        .PRE_W       (24),
        .RST_PATTERN (8'h01)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_rd(input string tag, input logic [2:0] a, input logic [31:0] e);
        sb_entry_t x;
        x.tag = tag; x.kind = K_RD; x.addr = a; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic exp_out(input string tag, input logic [7:0] e);
        sb_entry_t x;
        x.tag = tag; x.kind = K_OUT; x.addr = 3'd0; x.exp = {24'h0, e};
        sb.push_back(x);
    endtask

    task automatic exp_irq(input string tag, input logic e);
        sb_entry_t x;
        x.tag = tag; x.kind = K_IRQ; x.addr = 3'd0; x.exp = {31'h0, e};
        sb.push_back(x);
    endtask

    // Called just after a negedge; each read costs 1 time unit, well inside the low phase.
    task automatic drain();
        sb_entry_t   x;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.kind)
                K_RD: begin
                    address = x.addr;
                    #1;
                    obs = readdata;
                end
                K_OUT:   obs = {24'h0, out_port};
                default: obs = {31'h0, irq};
            endcase
            check_eq(x.tag, obs, x.exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        step(3);
        reset = 1'b0;

        // Reset state
        exp_out("rst_out", 8'h01);
        exp_irq("rst_irq", 1'b0);
        exp_rd("rst_data", 3'd0, 32'h01);
        exp_rd("rst_ctrl", 3'd1, 32'h0);
        exp_rd("rst_pre", 3'd2, 32'h00FF_FFFF);
        exp_rd("rst_stat", 3'd3, 32'h0);
        exp_rd("rst_a7", 3'd7, 32'h0);
        drain();

        // Rotate left, PRESCALE=3: one shift per 4 cycles, wrap on 0x80 -> 0x01
        cpu_write(3'd2, 32'd3);
        exp_rd("rot_pre", 3'd2, 32'd3);
        drain();
        cpu_write(3'd1, 32'h01);
        exp_rd("rot_d0", 3'd0, 32'h01);
        exp_rd("rot_stat0", 3'd3, 32'h2);
        drain();
        step(3);
        exp_rd("rot_hold", 3'd0, 32'h01);
        drain();
        for (int unsigned i = 1; i < 8; i++) begin
            step(4);
            exp_rd($sformatf("rot_d%0d", i), 3'd0, 32'h1 << i);
            drain();
        end
        exp_rd("rot_nowrap", 3'd3, 32'h2);
        drain();
        step(4);
        exp_rd("rot_d_wrap", 3'd0, 32'h01);
        exp_rd("rot_stat_wrap", 3'd3, 32'h3);
        exp_irq("rot_irq_masked", 1'b0);
        drain();

        // Bounce right from 0x01, PRESCALE=0: immediate flip then walk left
        do_reset();
        cpu_write(3'd0, 32'h01);
        cpu_write(3'd2, 32'h0);
        cpu_write(3'd1, 32'h07);
        exp_rd("bnc_d0", 3'd0, 32'h01);
        drain();
        step(1);
        exp_rd("bnc_d1", 3'd0, 32'h02);
        exp_rd("bnc_ctrl1", 3'd1, 32'h05);
        exp_rd("bnc_stat1", 3'd3, 32'h3);
        drain();
        step(6);
        exp_rd("bnc_d7", 3'd0, 32'h80);
        exp_rd("bnc_ctrl7", 3'd1, 32'h05);
        drain();
        step(1);
        exp_rd("bnc_d8", 3'd0, 32'h40);
        exp_rd("bnc_ctrl8", 3'd1, 32'h07);
        drain();

        // SET / CLR / TGL and invert
        do_reset();
        cpu_write(3'd0, 32'h0F);
        cpu_write(3'd4, 32'hF0);
        exp_rd("set", 3'd0, 32'hFF);
        exp_rd("set_rd0", 3'd4, 32'h0);
        drain();
        cpu_write(3'd5, 32'h81);
        exp_rd("clr", 3'd0, 32'h7E);
        drain();
        cpu_write(3'd6, 32'hFF);
        exp_rd("tgl", 3'd0, 32'h81);
        exp_out("tgl_out", 8'h81);
        drain();
        cpu_write(3'd1, 32'h08);
        exp_out("inv_out", 8'h7E);
        exp_rd("inv_data", 3'd0, 32'h81);
        drain();

        // irq, write-1-to-clear, clear colliding with a wrap
        do_reset();
        cpu_write(3'd2, 32'h0);
        cpu_write(3'd0, 32'h80);
        cpu_write(3'd1, 32'h11);
        exp_irq("irq_pre", 1'b0);
        drain();
        step(1);
        exp_irq("irq_set", 1'b1);
        exp_rd("irq_d", 3'd0, 32'h01);
        drain();
        cpu_write(3'd3, 32'h1);
        exp_irq("irq_clr", 1'b0);
        exp_rd("irq_stat_clr", 3'd3, 32'h2);
        drain();
        step(6);
        exp_rd("coll_d", 3'd0, 32'h80);
        exp_irq("coll_irq_pre", 1'b0);
        drain();
        cpu_write(3'd3, 32'h1);
        exp_rd("coll_stat", 3'd3, 32'h3);
        exp_irq("coll_irq", 1'b1);
        exp_rd("coll_d2", 3'd0, 32'h01);
        drain();

        // DATA write coincident with a tick, then reset overriding a write mid-run
        do_reset();
        cpu_write(3'd2, 32'd3);
        cpu_write(3'd1, 32'h01);
        step(3);
        cpu_write(3'd0, 32'h55);
        exp_rd("wr_tick_d", 3'd0, 32'h55);
        drain();
        step(3);
        exp_rd("wr_tick_hold", 3'd0, 32'h55);
        drain();
        step(1);
        exp_rd("wr_tick_next", 3'd0, 32'hAA);
        exp_rd("wr_tick_stat", 3'd3, 32'h2);
        drain();
        reset      = 1'b1;
        address    = 3'd0;
        writedata  = 32'h33;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_rd("mid_rst_d", 3'd0, 32'h01);
        exp_rd("mid_rst_ctrl", 3'd1, 32'h0);
        exp_rd("mid_rst_pre", 3'd2, 32'h00FF_FFFF);
        exp_out("mid_rst_out", 8'h01);
        drain();
        step(5);
        exp_rd("mid_rst_idle", 3'd0, 32'h01);
        exp_rd("mid_rst_stat", 3'd3, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
